// File: rtl/out_port_display_buffer_if.sv
// Write-side handshake between the CPU output port and the display buffer.
// A byte transfers on a rising clock edge where wr_valid and wr_ready are both high.
interface out_port_display_buffer_if #(
   parameter int unsigned W = 8
);

   logic         wr_valid;
   logic         wr_ready;
   logic [W-1:0] wr_data;

   // CPU output port side: offers bytes, observes back-pressure
   modport master (
      output wr_valid,
      output wr_data,
      input  wr_ready
   );

   // Display buffer side: accepts bytes, raises back-pressure
   modport slave (
      input  wr_valid,
      input  wr_data,
      output wr_ready
   );

endinterface

// File: rtl/out_port_display_buffer.sv
// out_port_display_buffer
//  Queues bytes written by the CPU output port in a DEPTH-entry FIFO. It presents
//  them one at a time on disp_byte, which feeds the seven-segment decoder input.
//  Each popped byte stays on the display for at least DWELL clocks.
//  The writer is back-pressured through wr_ready, which is decoded from the
//  registered queue count, so there is no combinational path from wr_valid.
//  Optional feature macro: DISP_SKIP_EN. When it is defined, the module gets a
//  'skip' input that ends the current dwell early while a byte is showing.
module out_port_display_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DWELL = 25_000_000,
   parameter int unsigned W     = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   out_port_display_buffer_if.slave     wr,
`ifdef DISP_SKIP_EN
   input  logic                         skip,
`endif
   output logic [W-1:0]                 disp_byte,
   output logic                         disp_new,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned TW = $clog2(DWELL + 1);

   typedef enum logic {
      IDLE = 1'b0,
      SHOW = 1'b1
   } state_e;

   state_e          state_q;
   logic [TW-1:0]   timer_q;
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic            ready_q;
   logic [W-1:0]    disp_q;
   logic            disp_new_q;
   logic [W-1:0]    mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic            expire;
   logic            skip_req;

   // Early-expiry request; tied low when the skip feature is not built
`ifdef DISP_SKIP_EN
   assign skip_req = skip;
`else
   assign skip_req = 1'b0;
`endif

   // Handshake, dwell expiry, pop decision and next queue count
   always_comb begin
      push    = wr.wr_valid & ready_q;
      expire  = (state_q == SHOW) && ((timer_q == '0) || skip_req);
      pop     = (count_q != '0) && ((state_q == IDLE) || expire);
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // FIFO storage; contents need no reset because the count gates every read
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr.wr_data;
      end
   end

   // Dwell FSM, pointers, count and registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ready_q    <= 1'b1;
         disp_q     <= '0;
         disp_new_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end

         case (state_q)
            IDLE: begin
               if (pop) begin
                  rd_ptr_q <= rd_ptr_q + PW'(1);
                  disp_q   <= mem_q[rd_ptr_q];
                  timer_q  <= TW'(DWELL - 1);
                  state_q  <= SHOW;
               end
            end
            SHOW: begin
               if (pop) begin
                  // Dwell over with more queued: next byte goes straight up
                  rd_ptr_q <= rd_ptr_q + PW'(1);
                  disp_q   <= mem_q[rd_ptr_q];
                  timer_q  <= TW'(DWELL - 1);
               end else if (expire) begin
                  // Dwell over and nothing queued: last byte stays lit
                  timer_q  <= '0;
                  state_q  <= IDLE;
               end else begin
                  timer_q  <= timer_q - TW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               timer_q <= '0;
            end
         endcase

         count_q    <= count_d;
         ready_q    <= (count_d < CW'(DEPTH));
         disp_new_q <= pop;
      end
   end

   assign wr.wr_ready  = ready_q;
   assign disp_byte    = disp_q;
   assign disp_new     = disp_new_q;
   assign fifo_count   = count_q;

endmodule

// File: tb/tb_out_port_display_buffer.sv
// Directed bench for out_port_display_buffer with DEPTH=4 and DWELL=4.
// When DISP_SKIP_EN is defined, it adds a second instance with DWELL=1000 to exercise skip.
module tb_out_port_display_buffer;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] disp_byte;
   logic       disp_new;
   logic [2:0] fifo_count;

   int errors = 0;
   int checks = 0;

   out_port_display_buffer_if #(.W(8)) wr_if ();

   always #5 CLK = ~CLK;

   out_port_display_buffer #(.DEPTH(4), .DWELL(4), .W(8)) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .wr         (wr_if.slave),
`ifdef DISP_SKIP_EN
      .skip       (1'b0),
`endif
      .disp_byte  (disp_byte),
      .disp_new   (disp_new),
      .fifo_count (fifo_count)
   );

`ifdef DISP_SKIP_EN
   logic       skip_s = 1'b0;
   logic [7:0] disp_byte2;
   logic       disp_new2;
   logic [2:0] fifo_count2;

   out_port_display_buffer_if #(.W(8)) wr2_if ();

   out_port_display_buffer #(.DEPTH(4), .DWELL(1000), .W(8)) u_dut_skip (
      .CLK        (CLK),
      .RST        (RST),
      .wr         (wr2_if.slave),
      .skip       (skip_s),
      .disp_byte  (disp_byte2),
      .disp_new   (disp_new2),
      .fifo_count (fifo_count2)
   );
`endif

   // Count one comparison and report it if observed differs from expected
   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   initial begin
      logic [7:0] seen [$];
      int         when [$];
      int         idx;
      int         fall_at;
      int         pulses;
      logic       pending;

      wr_if.wr_valid = 1'b0;
      wr_if.wr_data  = 8'h00;
`ifdef DISP_SKIP_EN
      wr2_if.wr_valid = 1'b0;
      wr2_if.wr_data  = 8'h00;
`endif

      // 1: asynchronous reset before any clock edge
      #2 RST = 1'b1;
      #1;
      check_eq("rst_disp_byte", 32'(disp_byte), 32'h00);
      check_eq("rst_wr_ready", 32'(wr_if.wr_ready), 32'h1);
      check_eq("rst_fifo_count", 32'(fifo_count), 32'h0);
      check_eq("rst_disp_new", 32'(disp_new), 32'h0);
      repeat (2) @(negedge CLK);
      RST = 1'b0;

      // 2: single write shown one edge after accept, then held
      @(negedge CLK);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 8'hA5;
      @(negedge CLK);
      wr_if.wr_valid = 1'b0;
      check_eq("single_count_after_accept", 32'(fifo_count), 32'h1);
      check_eq("single_disp_not_yet", 32'(disp_byte), 32'h00);
      @(negedge CLK);
      check_eq("single_disp", 32'(disp_byte), 32'hA5);
      check_eq("single_disp_new", 32'(disp_new), 32'h1);
      check_eq("single_count_after_pop", 32'(fifo_count), 32'h0);
      pulses = 0;
      repeat (10) begin
         @(negedge CLK);
         if (disp_new) pulses++;
      end
      check_eq("single_no_more_pulses", 32'(pulses), 32'h0);
      check_eq("single_held", 32'(disp_byte), 32'hA5);

      // 3: burst 01..06 with back-pressure
      idx     = 0;
      fall_at = -1;
      pending = 1'b0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge CLK);
         if (disp_new) begin
            seen.push_back(disp_byte);
            when.push_back(cyc);
         end
         if (pending) idx++;
         pending = 1'b0;
         if (!wr_if.wr_ready && fall_at < 0) fall_at = idx;
         if (idx < 6) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = 8'(idx + 1);
            pending        = wr_if.wr_ready;
         end else begin
            wr_if.wr_valid = 1'b0;
         end
      end
      check_eq("burst_ready_fall_after", 32'(fall_at), 32'd5);
      check_eq("burst_pulses", 32'(seen.size()), 32'd6);
      for (int i = 0; i < seen.size(); i++) begin
         check_eq($sformatf("burst_byte%0d", i), 32'(seen[i]), 32'(i + 1));
         if (i > 0) check_eq($sformatf("burst_gap%0d", i), 32'(when[i] - when[i-1]), 32'd4);
      end
      check_eq("burst_final_count", 32'(fifo_count), 32'h0);

      // 4: push on the same edge as a pop keeps count and order
      @(negedge CLK);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 8'h22;
      @(negedge CLK);
      wr_if.wr_data  = 8'h33;
      @(negedge CLK);
      wr_if.wr_valid = 1'b0;
      check_eq("pushpop_count", 32'(fifo_count), 32'h1);
      check_eq("pushpop_disp22", 32'(disp_byte), 32'h22);
      check_eq("pushpop_new22", 32'(disp_new), 32'h1);
      repeat (3) @(negedge CLK);
      check_eq("pushpop_still22", 32'(disp_byte), 32'h22);
      check_eq("pushpop_no_new", 32'(disp_new), 32'h0);
      @(negedge CLK);
      check_eq("pushpop_disp33", 32'(disp_byte), 32'h33);
      check_eq("pushpop_new33", 32'(disp_new), 32'h1);
      check_eq("pushpop_count0", 32'(fifo_count), 32'h0);
      repeat (6) @(negedge CLK);

      // 5: reset while showing with three queued
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         wr_if.wr_valid = 1'b1;
         wr_if.wr_data  = 8'(8'h44 + 8'(i) * 8'h11);
      end
      @(negedge CLK);
      wr_if.wr_valid = 1'b0;
      check_eq("prereset_count", 32'(fifo_count), 32'h3);
      check_eq("prereset_disp", 32'(disp_byte), 32'h44);
      #2 RST = 1'b1;
      #1;
      check_eq("midrst_disp", 32'(disp_byte), 32'h00);
      check_eq("midrst_count", 32'(fifo_count), 32'h0);
      check_eq("midrst_ready", 32'(wr_if.wr_ready), 32'h1);
      check_eq("midrst_new", 32'(disp_new), 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      pulses = 0;
      repeat (8) begin
         @(negedge CLK);
         if (disp_new) pulses++;
      end
      check_eq("postrst_pulses", 32'(pulses), 32'h0);
      check_eq("postrst_disp", 32'(disp_byte), 32'h00);
      @(negedge CLK);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = 8'h99;
      @(negedge CLK);
      wr_if.wr_valid = 1'b0;
      @(negedge CLK);
      check_eq("postrst_write_disp", 32'(disp_byte), 32'h99);
      check_eq("postrst_write_new", 32'(disp_new), 32'h1);

`ifdef DISP_SKIP_EN
      // 6: skip ends a long dwell early
      @(negedge CLK);
      wr2_if.wr_valid = 1'b1;
      wr2_if.wr_data  = 8'h11;
      @(negedge CLK);
      wr2_if.wr_data  = 8'h22;
      @(negedge CLK);
      wr2_if.wr_valid = 1'b0;
      check_eq("skip_disp11", 32'(disp_byte2), 32'h11);
      check_eq("skip_count1", 32'(fifo_count2), 32'h1);
      skip_s = 1'b1;
      @(negedge CLK);
      skip_s = 1'b0;
      check_eq("skip_disp22", 32'(disp_byte2), 32'h22);
      check_eq("skip_new", 32'(disp_new2), 32'h1);
      check_eq("skip_count0", 32'(fifo_count2), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
